// File: rtl/seed_sbox_seq_if.sv
// Request/response bundle for the sequential SEED S-box engine.
// The master issues start/sel/din and observes busy/done/dout.
interface seed_sbox_seq_if;
  logic       start;
  logic       sel;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [7:0] dout;

  modport master (output start, sel, din, input busy, done, dout);
  modport slave  (input start, sel, din, output busy, done, dout);
endinterface

// File: rtl/seed_sbox_seq.sv
// Sequential SEED S-box: S1(x) = A1*x^247 ^ 0xA9, S2(x) = A2*x^251 ^ 0x38.
// One shared GF(2^8) multiplier runs a square-and-multiply ladder, MSB first.
// Every exponent bit costs a square cycle and a multiply cycle, with a
// multiply by 1 for zero bits, so the latency does not depend on the data.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// SQR   | acc <= acc*acc
// MUL   | acc <= acc*x (exponent bit set) or acc*1; step to next bit
// AFF   | apply the affine map of the selected S-box into dout
// DONE  | one-cycle done pulse, then back to IDLE
module seed_sbox_seq #(
  parameter logic [7:0] POLY = 8'h63
) (
  input  logic           clk,
  input  logic           rst,
  seed_sbox_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SQR, MUL, AFF, DONE} state_t;

  localparam logic [7:0] EXP_S1 = 8'b1111_0111;
  localparam logic [7:0] EXP_S2 = 8'b1111_1011;
  localparam logic [7:0] AFF_C1 = 8'hA9;
  localparam logic [7:0] AFF_C2 = 8'h38;

  // Columns of the affine matrices: entry c is the image of input bit c.
  localparam logic [7:0] A1_COL [8] = '{8'h2C, 8'hD0, 8'h69, 8'hC2,
                                        8'h41, 8'h44, 8'h58, 8'hE2};
  localparam logic [7:0] A2_COL [8] = '{8'hD0, 8'h2A, 8'hE1, 8'h2C,
                                        8'h21, 8'h30, 8'hA2, 8'h6C};

  state_t     state;
  logic [7:0] acc;
  logic [7:0] x_reg;
  logic       sel_reg;
  logic [2:0] idx;
  logic       busy_q;
  logic       done_q;
  logic [7:0] dout_q;

  logic [7:0] exp_bits;
  logic [7:0] mul_b;
  logic [7:0] mul_p;

  // Carry-less 8x8 product (15 bits) folded back modulo {1,POLY}.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'({1'b1, POLY}) << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] v, input logic s);
    logic [7:0] r;
    r = s ? AFF_C2 : AFF_C1;
    for (int c = 0; c < 8; c++)
      if (v[c]) r = r ^ (s ? A2_COL[c] : A1_COL[c]);
    return r;
  endfunction

  assign exp_bits = sel_reg ? EXP_S2 : EXP_S1;
  assign mul_b    = (state == SQR) ? acc : (exp_bits[idx] ? x_reg : 8'h01);
  assign mul_p    = gf_mul(acc, mul_b);

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;

  // Sequencer with registered busy/done/dout; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= 8'h01;
      x_reg   <= 8'h00;
      sel_reg <= 1'b0;
      idx     <= 3'd7;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_reg   <= bus.din;
            sel_reg <= bus.sel;
            acc     <= 8'h01;
            idx     <= 3'd7;
            busy_q  <= 1'b1;
            state   <= SQR;
          end
        end
        SQR: begin
          acc   <= mul_p;
          state <= MUL;
        end
        MUL: begin
          acc <= mul_p;
          if (idx == 3'd0) begin
            state <= AFF;
          end else begin
            idx   <= idx - 3'd1;
            state <= SQR;
          end
        end
        AFF: begin
          dout_q <= affine(acc, sel_reg);
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_sbox_seq.sv
// Bench for seed_sbox_seq. The reference builds S1/S2 from the textbook
// definition: x^e by repeated GF multiplication, then a row-parity affine map.
module tb_seed_sbox_seq;

  logic clk = 1'b0;
  logic rst;

  seed_sbox_seq_if bus ();

  seed_sbox_seq #(.POLY(8'h63)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Affine matrix rows: output bit r is the parity of (row r & input).
  localparam int ROWS1 [8] = '{'h14, 'h88, 'h21, 'h45, 'h42, 'h85, 'hFE, 'h8A};
  localparam int ROWS2 [8] = '{'h14, 'h42, 'h88, 'h8A, 'h21, 'hFE, 'h85, 'h45};

  logic [7:0] ref_tab [2][256];

  function automatic int ref_mul(int a_in, int b);
    int a;
    int r;
    a = a_in;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) r = r ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h163;
    end
    return r;
  endfunction

  function automatic int ref_pow(int x, int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = ref_mul(r, x);
    return r;
  endfunction

  function automatic int ref_sbox(int s, int x);
    int y;
    int r;
    y = ref_pow(x, (s != 0) ? 251 : 247);
    r = 0;
    for (int i = 0; i < 8; i++)
      if (($countones(((s != 0) ? ROWS2[i] : ROWS1[i]) & y) % 2) == 1)
        r = r | (1 << i);
    return r ^ ((s != 0) ? 'h38 : 'hA9);
  endfunction

  // One request; din/sel are scrambled while busy. lat = -1 on timeout.
  task automatic run_req(input logic s, input logic [7:0] d,
                         output logic [7:0] res, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = s;
    bus.din   = d;
    lat = -1;
    res = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.sel   = 1'($urandom_range(0, 1));
      bus.din   = 8'($urandom_range(0, 255));
      if (bus.done === 1'b1) begin
        lat = k;
        res = bus.dout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.sel   = 1'b1;
    bus.din   = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done);
    else n_pass++;
    n_checks++;
    if (bus.dout !== 8'h00) $display("FAIL reset_dout got=%02h want=00", bus.dout);
    else n_pass++;
    rst       = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = 1'b0;
    bus.din   = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.busy !== ((k <= 18) ? 1'b1 : 1'b0))
        $display("FAIL basic_busy cycle=%0d got=%b want=%b", k, bus.busy, (k <= 18));
      else n_pass++;
      n_checks++;
      if (bus.done !== ((k == 18) ? 1'b1 : 1'b0))
        $display("FAIL basic_done cycle=%0d got=%b want=%b", k, bus.done, (k == 18));
      else n_pass++;
      if (k == 18) begin
        n_checks++;
        if (bus.dout !== 8'hA9) $display("FAIL basic_dout got=%02h want=a9", bus.dout);
        else n_pass++;
      end
    end
  endtask

  task automatic test_known();
    logic       sels [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] dins [5] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02};
    logic [7:0] outs [5] = '{8'h38, 8'h85, 8'hE8, 8'hD6, 8'h2D};
    logic [7:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_req(sels[i], dins[i], res, lat);
      n_checks++;
      if (res !== outs[i])
        $display("FAIL known_dout sel=%0d din=%02h got=%02h want=%02h", sels[i], dins[i], res, outs[i]);
      else n_pass++;
      n_checks++;
      if (lat != 18) $display("FAIL known_latency got=%0d want=18", lat);
      else n_pass++;
    end
  endtask

  task automatic test_ignore();
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] e0;
    logic [7:0] e1;
    d0 = 8'h55;
    d1 = 8'h3C;
    e0 = ref_tab[0][d0];
    e1 = ref_tab[1][d1];
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = 1'b0;
    bus.din   = d0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== ((k == 18) ? 1'b1 : 1'b0))
        $display("FAIL ignore_done cycle=%0d got=%b want=%b", k, bus.done, (k == 18));
      else n_pass++;
      if (k == 18) begin
        n_checks++;
        if (bus.dout !== e0) $display("FAIL ignore_dout got=%02h want=%02h", bus.dout, e0);
        else n_pass++;
      end
      if (k == 19) begin
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL ignore_idle_busy got=%b want=0", bus.busy);
        else n_pass++;
      end
      if (k == 5 || k == 18) begin
        bus.start = 1'b1;
        bus.sel   = 1'b1;
        bus.din   = 8'hAA;
      end else if (k == 19) begin
        bus.start = 1'b1;
        bus.sel   = 1'b1;
        bus.din   = d1;
      end else begin
        bus.start = 1'b0;
        bus.sel   = 1'($urandom_range(0, 1));
        bus.din   = 8'($urandom_range(0, 255));
      end
    end
    for (int k = 20; k <= 38; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.done !== ((k == 37) ? 1'b1 : 1'b0))
        $display("FAIL ignore_second_done cycle=%0d got=%b want=%b", k, bus.done, (k == 37));
      else n_pass++;
      n_checks++;
      if (bus.dout !== ((k >= 37) ? e1 : e0))
        $display("FAIL ignore_dout_hold cycle=%0d got=%02h want=%02h", k, bus.dout, (k >= 37) ? e1 : e0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d2;
    logic [7:0] e2;
    d2 = 8'($urandom_range(0, 255));
    e2 = ref_tab[0][d2];
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = 1'b1;
    bus.din   = 8'($urandom_range(0, 255));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 9) rst = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL midreset_busy got=%b want=0", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.dout !== 8'h00) $display("FAIL midreset_dout got=%02h want=00", bus.dout);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = 1'b0;
    bus.din   = d2;
    for (int k = 12; k <= 30; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.done !== ((k == 29) ? 1'b1 : 1'b0))
        $display("FAIL midreset_done cycle=%0d got=%b want=%b", k, bus.done, (k == 29));
      else n_pass++;
      if (k == 29) begin
        n_checks++;
        if (bus.dout !== e2) $display("FAIL midreset_dout_new got=%02h want=%02h", bus.dout, e2);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic       s;
    logic [7:0] d;
    logic [7:0] res;
    int lat;
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      run_req(s, d, res, lat);
      n_checks++;
      if (res !== ref_tab[s][d])
        $display("FAIL random_dout sel=%0d din=%02h got=%02h want=%02h", s, d, res, ref_tab[s][d]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] res;
    int lat;
    for (int s = 0; s < 2; s++) begin
      for (int d = 0; d < 256; d++) begin
        run_req(1'(s), 8'(d), res, lat);
        n_checks++;
        if (res !== ref_tab[s][d])
          $display("FAIL sweep_dout sel=%0d din=%02h got=%02h want=%02h", s, d, res, ref_tab[s][d]);
        else n_pass++;
        n_checks++;
        if (lat != 18)
          $display("FAIL sweep_latency sel=%0d din=%02h got=%0d want=18", s, d, lat);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sel   = 1'b0;
    bus.din   = 8'h00;
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 256; d++)
        ref_tab[s][d] = 8'(ref_sbox(s, d));

    test_reset();
    test_basic();
    test_known();
    test_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seed_sbox_seq.md
SEED_SBOX_SEQ -- requirements
Module: seed_sbox_seq

Interface
REQ-001 Parameter POLY, default 8'h63, low 8 bits of the GF(2^8) reduction polynomial x^8+x^6+x^5+x+1 (0x163).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to compute one S-box value; sampled only in IDLE.
REQ-005 sel  input  1  S-box select; 0 = S1 (exponent 247), 1 = S2 (exponent 251); captured with start.
REQ-006 din  input  8  S-box input byte; captured with start.
REQ-007 busy  output  1  high from the cycle after start acceptance through the done cycle.
REQ-008 done  output  1  single-cycle pulse; dout is valid and new in this cycle.
REQ-009 dout  output  8  S-box result; held stable until the next done or reset.

Function
REQ-010 The block SHALL compute S1(x) = A1·x^247 xor 0xA9 and S2(x) = A2·x^251 xor 0x38, with the GF(2^8) arithmetic and affine matrices A1/A2 exactly as in the SEED specification (RFC 4269).
REQ-011 The block SHALL implement exponentiation with exactly one combinational GF(2^8) multiplier, time-shared across all steps, one multiply per cycle.
REQ-012 States SHALL be IDLE, SQR, MUL, AFF and DONE.
REQ-013 IDLE: start=1 captures din into x_reg and sel into sel_reg, sets acc=0x01, sets bit index=7, moves to SQR; start=0 stays in IDLE.
REQ-014 SQR: acc <= acc·acc; moves to MUL.
REQ-015 MUL: acc <= acc·x_reg if exponent bit[index]=1, else acc <= acc·0x01. Exponent is 8'b11110111 (S1) or 8'b11111011 (S2), processed MSB first. If index=0, moves to AFF; otherwise decrements index and moves to SQR.
REQ-016 Every bit SHALL take exactly 2 cycles regardless of its value, so latency is fixed and data-independent.
REQ-017 AFF: dout <= affine(acc) per sel_reg; moves to DONE.
REQ-018 DONE: done=1 for one cycle; moves to IDLE.
REQ-019 Timing: with start accepted in cycle 0, SQR/MUL occupy cycles 1-16, AFF is cycle 17, done=1 in cycle 18, and IDLE is re-entered in cycle 19; busy=1 in cycles 1-18.
REQ-020 start SHALL be ignored in every state other than IDLE; din and sel changes while busy SHALL NOT affect the result.
REQ-021 din=0x00 SHALL need no special case: acc becomes 0x00 at the first set exponent bit and the result is the affine constant.
REQ-022 dout SHALL change only in the AFF-to-DONE transition or on reset.
REQ-023 The multiplier SHALL reduce modulo {1,POLY}; all datapath widths are 8 bits and no intermediate state is wider than 15 bits.

Reset
REQ-024 With rst=1 at a clock edge, the next state SHALL be IDLE, with busy=0, done=0, dout=0x00, acc=0x01, x_reg=0x00, sel_reg=0 and index=7.
REQ-025 rst SHALL take priority over start and over every state transition, including in the middle of a computation (no done is produced for the aborted request).
REQ-026 start asserted in the first cycle after rst is released SHALL be accepted normally.

Verification
REQ-027 start=1, sel=0, din=0x00 in cycle 0 -> busy high in cycles 1-18, done=1 only in cycle 18, dout=0xA9.
REQ-028 sel=1, din=0x00 -> dout=0x38; sel=0, din=0x01 -> dout=0x85; sel=1, din=0x01 -> dout=0xE8; each with done exactly 18 cycles after start.
REQ-029 Pulse start again in cycles 5 and 18 with different din/sel -> both ignored, result unchanged, next start in cycle 19 accepted.
REQ-030 Assert rst in cycle 9 of a computation -> cycle 10 shows busy=0, dout=0x00, no done pulse; a new start in cycle 11 completes with done in cycle 29.
REQ-031 Exhaustive sweep, sel in {0,1} x din in 0x00-0xFF, back-to-back starts -> every dout matches the SEED S1/S2 tables and latency is always 18.
